// File: rtl/baccarat_ctrl.sv
// Baccarat hand sequencer: pulses the datapath card-load enables in deal order,
// applies the third-card drawing rules and latches the win/tie result.
module baccarat_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win,
    output logic       dealer_win,
    output logic       done
);

    typedef enum logic [2:0] {
        S_DEAL_P1 = 3'd0,
        S_DEAL_D1 = 3'd1,
        S_DEAL_P2 = 3'd2,
        S_DEAL_D2 = 3'd3,
        S_PLAYER3 = 3'd4,
        S_DEALER3 = 3'd5,
        S_RESULT  = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    state_t     state_q;
    logic       player_win_q;
    logic       dealer_win_q;
    logic       done_q;
    logic       go_s;
    logic       natural_s;
    logic       player_draws_s;
    logic       dealer_draws_s;

    // Dealer third-card table; pcard3 face values 10..13 count as zero.
    function automatic logic dealer_rule(input logic [3:0] ds, input logic [3:0] pc);
        logic [3:0] v;
        logic       d;
        v = (pc >= 4'd10) ? 4'd0 : pc;
        case (ds)
            4'd0, 4'd1, 4'd2: d = 1'b1;
            4'd3:             d = (v != 4'd8);
            4'd4:             d = (v >= 4'd2) && (v <= 4'd7);
            4'd5:             d = (v >= 4'd4) && (v <= 4'd7);
            4'd6:             d = (v >= 4'd6) && (v <= 4'd7);
            default:          d = 1'b0;
        endcase
        return d;
    endfunction

    assign go_s           = rst_n && step;
    assign natural_s      = (pscore >= 4'd8) || (dscore >= 4'd8);
    assign player_draws_s = !natural_s && (pscore <= 4'd5);
    assign dealer_draws_s = dealer_rule(dscore, pcard3);

    // Mealy load strobes: one enable per accepted step, gated off during reset.
    always_comb begin
        load_pcard1 = 1'b0;
        load_pcard2 = 1'b0;
        load_pcard3 = 1'b0;
        load_dcard1 = 1'b0;
        load_dcard2 = 1'b0;
        load_dcard3 = 1'b0;
        case (state_q)
            S_DEAL_P1: load_pcard1 = go_s;
            S_DEAL_D1: load_dcard1 = go_s;
            S_DEAL_P2: load_pcard2 = go_s;
            S_DEAL_D2: load_dcard2 = go_s;
            S_PLAYER3: begin
                load_pcard3 = go_s && player_draws_s;
                load_dcard3 = go_s && !natural_s && !player_draws_s && (dscore <= 4'd5);
            end
            S_DEALER3: load_dcard3 = go_s && dealer_draws_s;
            default:   load_pcard1 = 1'b0;
        endcase
    end

    // Hand sequencing and result latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_DEAL_P1;
            player_win_q <= 1'b0;
            dealer_win_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            case (state_q)
                S_DEAL_P1: if (step) state_q <= S_DEAL_D1;
                S_DEAL_D1: if (step) state_q <= S_DEAL_P2;
                S_DEAL_P2: if (step) state_q <= S_DEAL_D2;
                S_DEAL_D2: if (step) state_q <= S_PLAYER3;
                S_PLAYER3: begin
                    if (step) begin
                        state_q <= player_draws_s ? S_DEALER3 : S_RESULT;
                    end
                end
                S_DEALER3: if (step) state_q <= S_RESULT;
                S_RESULT: begin
                    player_win_q <= (pscore >= dscore);
                    dealer_win_q <= (dscore >= pscore);
                    done_q       <= 1'b1;
                    state_q      <= S_DONE;
                end
                S_DONE:    state_q <= S_DONE;
                default:   state_q <= S_DEAL_P1;
            endcase
        end
    end

    assign player_win = player_win_q;
    assign dealer_win = dealer_win_q;
    assign done       = done_q;

endmodule

// File: tb/tb_baccarat_ctrl.sv
// Randomized bench for baccarat_ctrl: an action-queue model of the hand predicts
// every cycle's outputs into a scoreboard checked by an independent monitor.
module tb_baccarat_ctrl;

    logic       clk;
    logic       rst_n;
    logic       step;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic [3:0] pcard3;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win, dealer_win, done;

    baccarat_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .step        (step),
        .pscore      (pscore),
        .dscore      (dscore),
        .pcard3      (pcard3),
        .load_pcard1 (load_pcard1),
        .load_pcard2 (load_pcard2),
        .load_pcard3 (load_pcard3),
        .load_dcard1 (load_dcard1),
        .load_dcard2 (load_dcard2),
        .load_dcard3 (load_dcard3),
        .player_win  (player_win),
        .dealer_win  (dealer_win),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected vector: {p1,d1,p2,d2,p3,d3,player_win,dealer_win,done}
    logic [8:0] exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         n_draw_d3 = 0;
    int         n_tie = 0;

    typedef enum int {A_P1, A_D1, A_P2, A_D2, A_PDEC, A_DDEC} act_t;
    act_t plan[$];
    bit   result_pending;
    bit   finished;
    bit   m_pw, m_dw, m_done;
    int   done_cycles;

    function automatic bit banker_draws(int ds, int pc);
        int v;
        v = (pc >= 10) ? 0 : pc;
        if (ds <= 2) return 1'b1;
        if (ds == 3) return v != 8;
        if (ds == 4) return v >= 2 && v <= 7;
        if (ds == 5) return v >= 4 && v <= 7;
        if (ds == 6) return v == 6 || v == 7;
        return 1'b0;
    endfunction

    task automatic model_reset();
        plan = '{A_P1, A_D1, A_P2, A_D2, A_PDEC};
        result_pending = 1'b0;
        finished = 1'b0;
        m_pw = 1'b0;
        m_dw = 1'b0;
        m_done = 1'b0;
        done_cycles = 0;
    endtask

    // Monitor: compare every presented cycle against the oldest prediction.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [8:0] a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3,
                 load_dcard3, player_win, dealer_win, done};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs t=%0t got=%b want=%b (p1 d1 p2 d2 p3 d3 pw dw done) ps=%0d ds=%0d pc3=%0d",
                         $time, a, e, pscore, dscore, pcard3);
            end
        end
    end

    initial begin
        rst_n  = 1'b0;
        step   = 1'b0;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        if ({load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3,
             load_dcard3, player_win, dealer_win, done} !== 9'b0) begin
            n_bad++;
            $display("FAIL reset state t=%0t got=%b want=000000000", $time,
                     {load_pcard1, load_dcard1, load_pcard2, load_dcard2, load_pcard3,
                      load_dcard3, player_win, dealer_win, done});
        end
        model_reset();
        for (int cyc = 0; cyc < 20000; cyc++) begin
            logic [5:0] ld;
            bit         pend_next;
            bit         nx_pw, nx_dw, nx_done, nx_fin, do_reset;
            int         ps, ds, pc;

            do_reset = ($urandom_range(0, 249) == 0) ||
                       (finished && done_cycles >= 2 && $urandom_range(0, 2) == 0);
            ps = $urandom_range(0, 9);
            ds = $urandom_range(0, 9);
            pc = $urandom_range(0, 13);
            rst_n  = !do_reset;
            step   = ($urandom_range(0, 9) < 7);
            pscore = 4'(ps);
            dscore = 4'(ds);
            pcard3 = 4'(pc);

            ld = 6'b0;
            pend_next = result_pending;
            nx_pw = m_pw; nx_dw = m_dw; nx_done = m_done; nx_fin = finished;
            if (!do_reset) begin
                if (result_pending) begin
                    nx_pw = (ps >= ds);
                    nx_dw = (ds >= ps);
                    nx_done = 1'b1;
                    nx_fin = 1'b1;
                    pend_next = 1'b0;
                    if (ps == ds) n_tie++;
                end else if (step && !finished && plan.size() > 0) begin
                    act_t a;
                    a = plan.pop_front();
                    case (a)
                        A_P1: ld[5] = 1'b1;
                        A_D1: ld[4] = 1'b1;
                        A_P2: ld[3] = 1'b1;
                        A_D2: ld[2] = 1'b1;
                        A_PDEC: begin
                            if (ps >= 8 || ds >= 8) begin
                                pend_next = 1'b1;
                            end else if (ps <= 5) begin
                                ld[1] = 1'b1;
                                plan.push_back(A_DDEC);
                            end else begin
                                ld[0] = (ds <= 5);
                                pend_next = 1'b1;
                            end
                        end
                        default: begin
                            ld[0] = banker_draws(ds, pc);
                            if (ld[0]) n_draw_d3++;
                            pend_next = 1'b1;
                        end
                    endcase
                end
            end
            exp_q.push_back({ld, m_pw, m_dw, m_done});

            if (do_reset) begin
                model_reset();
            end else begin
                result_pending = pend_next;
                m_pw = nx_pw; m_dw = nx_dw; m_done = nx_done;
                if (finished) done_cycles++;
                finished = nx_fin;
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        step  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0 || n_cmp != 20000) begin
            n_bad++;
            $display("FAIL expired wait: %0d predictions left, %0d compared (want 20000)",
                     exp_q.size(), n_cmp);
        end
        $display("info: dealer third draws=%0d ties=%0d", n_draw_d3, n_tie);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
